trigger_hit_map_decoder: RTL and testbench

//  Inverse of the trigger-info channel encoder: takes a stream of 9-bit channel indices.

---
 rtl/trigger_hit_map_decoder.sv | 186 ++++++++++++++++++
 tb/tb_trigger_hit_map_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_hit_map_decoder.sv
// -----------------------------------------------------------------------------
// trigger_hit_map_decoder
//
// Purpose:
//   Collects a stream of encoded channel indices into a per-event hit map.
//   The first in-range hit opens a coincidence window of WINDOW cycles. Every
//   in-range hit inside that window sets its channel bit. When the window
//   closes, the map is held and offered to the trigger-matching logic over a
//   valid/ready handshake. This block is the inverse of the trigger-info
//   channel encoder.
//
// Parameters:
//   NCH     channel count and map width; valid index range is 0..NCH-1
//   IDX_W   index width, matches the encoder output
//   WINDOW  coincidence window length in clk cycles (>=1), counted from the
//           cycle of the first hit
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous reset, active low
//   idx_in     in   channel index of a hit
//   idx_valid  in   idx_in qualifier, one hit per cycle
//   map_out    out  collected hit map, bit i = channel i hit in the window
//   map_valid  out  map_out/hit_count complete and stable
//   map_ready  in   consumer accepts the map when map_valid & map_ready
//   hit_count  out  number of distinct bits set in map_out
//   busy       out  high while collecting or holding a map
//   range_err  out  1-cycle pulse, one cycle late: idx_in >= NCH was strobed
//   lost_hit   out  1-cycle pulse, one cycle late: in-range hit dropped while
//                   a completed map waits for the consumer
// -----------------------------------------------------------------------------
module trigger_hit_map_decoder #(
    parameter int NCH    = 128,
    parameter int IDX_W  = 9,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_in,
    input  logic             idx_valid,
    output logic [NCH-1:0]   map_out,
    output logic             map_valid,
    input  logic             map_ready,
    output logic [7:0]       hit_count,
    output logic             busy,
    output logic             range_err,
    output logic             lost_hit
);

    // The first-hit cycle is window cycle 0 and is spent in IDLE, so the
    // counter only has to cover the remaining WINDOW-1 cycles. It is loaded
    // with WINDOW-2 and the cycle on which it reads zero is the last one.
    localparam int WCW = (WINDOW > 2) ? $clog2(WINDOW - 1) : 1;
    localparam logic [WCW-1:0] WIN_LOAD = (WINDOW >= 2) ? WCW'(WINDOW - 2) : '0;

    // A one-cycle window goes straight from the first hit to HOLD.
    localparam bit SINGLE_CYCLE = (WINDOW == 1);

    // One extra bit so the range compare also works when NCH == 2**IDX_W.
    localparam logic [IDX_W:0] NCH_L = (IDX_W + 1)'(NCH);

    localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [WCW-1:0] win_cnt_q,   win_cnt_d;
    logic [NCH-1:0] map_q,       map_d;
    logic [7:0]     cnt_q,       cnt_d;
    logic           map_valid_q, map_valid_d;
    logic           busy_q,      busy_d;
    logic           range_err_q, range_err_d;
    logic           lost_hit_q,  lost_hit_d;

    logic           idx_in_range;
    logic           hit;
    logic [NCH-1:0] hit_vec;
    logic           hit_is_new;

    // Range check is qualified by idx_valid: idx_in is don't-care otherwise.
    always_comb begin
        idx_in_range = ({1'b0, idx_in} < NCH_L);
        hit          = idx_valid && idx_in_range;
        hit_vec      = hit ? (ONE_HOT0 << idx_in) : '0;
        hit_is_new   = |(hit_vec & ~map_q);
    end

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        map_d       = map_q;
        cnt_d       = cnt_q;
        range_err_d = idx_valid && !idx_in_range;
        lost_hit_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    map_d     = hit_vec;
                    cnt_d     = 8'd1;
                    win_cnt_d = WIN_LOAD;
                    state_d   = SINGLE_CYCLE ? S_HOLD : S_COLLECT;
                end
            end

            S_COLLECT: begin
                // Duplicate hits OR into the map but must not bump the count.
                map_d = map_q | hit_vec;
                if (hit_is_new) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (win_cnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                end
            end

            S_HOLD: begin
                if (map_ready) begin
                    // A hit in the handshake cycle is the first hit of the
                    // next event rather than a lost one.
                    if (hit) begin
                        map_d     = hit_vec;
                        cnt_d     = 8'd1;
                        win_cnt_d = WIN_LOAD;
                        state_d   = SINGLE_CYCLE ? S_HOLD : S_COLLECT;
                    end else begin
                        map_d     = '0;
                        cnt_d     = 8'd0;
                        win_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
                end else if (hit) begin
                    lost_hit_d = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                map_d     = '0;
                cnt_d     = 8'd0;
                win_cnt_d = '0;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state register instead of trailing it by a cycle.
        busy_d      = (state_d != S_IDLE);
        map_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_cnt_q   <= '0;
            map_q       <= '0;
            cnt_q       <= 8'd0;
            map_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            range_err_q <= 1'b0;
            lost_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            map_q       <= map_d;
            cnt_q       <= cnt_d;
            map_valid_q <= map_valid_d;
            busy_q      <= busy_d;
            range_err_q <= range_err_d;
            lost_hit_q  <= lost_hit_d;
        end
    end

    assign map_out   = map_q;
    assign hit_count = cnt_q;
    assign map_valid = map_valid_q;
    assign busy      = busy_q;
    assign range_err = range_err_q;
    assign lost_hit  = lost_hit_q;

endmodule

// File: tb/tb_trigger_hit_map_decoder.sv
module tb_trigger_hit_map_decoder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [8:0]   idx_in;
    logic         idx_valid;
    logic         map_ready;

    logic [127:0] map_out16, map_out1;
    logic         map_valid16, map_valid1;
    logic [7:0]   hit_count16, hit_count1;
    logic         busy16, busy1;
    logic         range_err16, range_err1;
    logic         lost_hit16, lost_hit1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    trigger_hit_map_decoder #(.NCH(128), .IDX_W(9), .WINDOW(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .idx_in(idx_in), .idx_valid(idx_valid),
        .map_out(map_out16), .map_valid(map_valid16), .map_ready(map_ready),
        .hit_count(hit_count16), .busy(busy16), .range_err(range_err16),
        .lost_hit(lost_hit16)
    );

    trigger_hit_map_decoder #(.NCH(128), .IDX_W(9), .WINDOW(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .idx_in(idx_in), .idx_valid(idx_valid),
        .map_out(map_out1), .map_valid(map_valid1), .map_ready(map_ready),
        .hit_count(hit_count1), .busy(busy1), .range_err(range_err1),
        .lost_hit(lost_hit1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an event is "open" from its first-hit cycle; cycles
    // before start+W collect, later cycles hold. The count is simply the
    // population count of the map. Index 0 -> WINDOW=16, index 1 -> WINDOW=1.
    // ------------------------------------------------------------------
    int           cyc = 0;
    bit           m_open  [2];
    int           m_start [2];
    logic [127:0] m_map   [2];
    bit           m_err   [2];
    bit           m_lost  [2];
    bit           e_valid [2];

    int           mw;
    bit           m_inr;
    logic [127:0] m_bit;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mw    = (k == 0) ? 16 : 1;
            m_inr = idx_valid && (int'(idx_in) < 128);
            m_bit = 128'd1 << idx_in;
            if (!rst_n) begin
                m_open[k] = 1'b0;
                m_map[k]  = '0;
                m_err[k]  = 1'b0;
                m_lost[k] = 1'b0;
            end else begin
                m_err[k]  = idx_valid && !m_inr;
                m_lost[k] = 1'b0;
                if (!m_open[k]) begin
                    if (m_inr) begin
                        m_open[k] = 1'b1; m_start[k] = cyc; m_map[k] = m_bit;
                    end
                end else if (cyc < m_start[k] + mw) begin
                    if (m_inr) m_map[k] = m_map[k] | m_bit;
                end else if (map_ready) begin
                    if (m_inr) begin
                        m_start[k] = cyc; m_map[k] = m_bit;
                    end else begin
                        m_open[k] = 1'b0; m_map[k] = '0;
                    end
                end else if (m_inr) begin
                    m_lost[k] = 1'b1;
                end
            end
            e_valid[k] = m_open[k] && (cyc + 1 >= m_start[k] + mw);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("w16.map_out",   map_out16,   m_map[0]);
            chk("w16.map_valid", map_valid16, e_valid[0]);
            chk("w16.hit_count", hit_count16, $countones(m_map[0]));
            chk("w16.busy",      busy16,      m_open[0]);
            chk("w16.range_err", range_err16, m_err[0]);
            chk("w16.lost_hit",  lost_hit16,  m_lost[0]);
            chk("w1.map_out",    map_out1,    m_map[1]);
            chk("w1.map_valid",  map_valid1,  e_valid[1]);
            chk("w1.hit_count",  hit_count1,  $countones(m_map[1]));
            chk("w1.busy",       busy1,       m_open[1]);
            chk("w1.range_err",  range_err1,  m_err[1]);
            chk("w1.lost_hit",   lost_hit1,   m_lost[1]);
        end
    end

    // Advance n clock edges; returns 1 time unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic hit(input int idx);
        idx_valid = 1'b1;
        idx_in    = 9'(idx);
    endtask

    initial begin
        rst_n = 1'b0; idx_in = '0; idx_valid = 1'b0; map_ready = 1'b0;
        tick(2);
        cmp_en = 1'b1;
        chk("rst.map_valid", map_valid16, 1'b0);
        chk("rst.busy",      busy16,      1'b0);
        chk("rst.hit_count", hit_count16, 8'd0);
        rst_n = 1'b1;
        tick(1);

        // 1. Reset in the middle of a window.
        hit(3); tick(1);
        hit(7); tick(1);
        idx_valid = 1'b0; rst_n = 1'b0; tick(1);
        chk("s1.map_out",   map_out16,   128'd0);
        chk("s1.hit_count", hit_count16, 8'd0);
        chk("s1.busy",      busy16,      1'b0);
        chk("s1.map_valid", map_valid16, 1'b0);
        rst_n = 1'b1;
        hit(9); tick(1);
        chk("s1.new_busy", busy16,    1'b1);
        chk("s1.new_map",  map_out16, 128'd1 << 9);
        idx_valid = 1'b0; map_ready = 1'b1;
        tick(20);

        // 2. Single hit, consumer always ready.
        hit(5); tick(1);
        idx_valid = 1'b0;
        tick(14);
        chk("s2.c15_valid", map_valid16, 1'b0);
        tick(1);
        chk("s2.c16_valid", map_valid16, 1'b1);
        chk("s2.c16_map",   map_out16,   128'd1 << 5);
        chk("s2.c16_count", hit_count16, 8'd1);
        tick(1);
        chk("s2.c17_valid", map_valid16, 1'b0);
        chk("s2.c17_busy",  busy16,      1'b0);
        map_ready = 1'b0;
        tick(2);

        // 3. Duplicates, last-cycle hit, hit dropped in HOLD.
        hit(0);   tick(1);
        hit(127); tick(1);
        hit(127); tick(1);
        idx_valid = 1'b0; tick(12);
        hit(64);  tick(1);
        hit(10);  tick(1);
        idx_valid = 1'b0;
        chk("s3.lost_hit",  lost_hit16,  1'b1);
        chk("s3.map",       map_out16,   (128'd1 << 127) | (128'd1 << 64) | 128'd1);
        chk("s3.hit_count", hit_count16, 8'd3);
        chk("s3.valid",     map_valid16, 1'b1);
        map_ready = 1'b1; tick(1);
        map_ready = 1'b0; tick(2);

        // 4. Out-of-range indices in IDLE; masked index when idx_valid=0.
        hit(128); tick(1);
        chk("s4.err128",  range_err16, 1'b1);
        chk("s4.busy128", busy16,      1'b0);
        hit(511); tick(1);
        chk("s4.err511",  range_err16, 1'b1);
        idx_valid = 1'b0; idx_in = 9'd200; tick(1);
        chk("s4.err_off", range_err16, 1'b0);
        chk("s4.valid",   map_valid16, 1'b0);
        chk("s4.busy",    busy16,      1'b0);
        tick(2);

        // 5. Hit in the handshake cycle starts the next event.
        hit(1); tick(1);
        idx_valid = 1'b0; tick(15);
        chk("s5.hold_valid", map_valid16, 1'b1);
        map_ready = 1'b1; hit(42); tick(1);
        map_ready = 1'b0; idx_valid = 1'b0;
        chk("s5.valid_low", map_valid16, 1'b0);
        chk("s5.busy",      busy16,      1'b1);
        chk("s5.map",       map_out16,   128'd1 << 42);
        chk("s5.count",     hit_count16, 8'd1);
        chk("s5.no_lost",   lost_hit16,  1'b0);
        tick(15);
        chk("s5.c32_valid", map_valid16, 1'b1);
        chk("s5.c32_map",   map_out16,   128'd1 << 42);
        map_ready = 1'b1; tick(1);
        map_ready = 1'b0; tick(2);

        // 6. One-cycle window (second instance).
        hit(2); tick(1);
        chk("s6.valid", map_valid1, 1'b1);
        chk("s6.map",   map_out1,   128'd1 << 2);
        chk("s6.count", hit_count1, 8'd1);
        hit(6); tick(1);
        idx_valid = 1'b0;
        chk("s6.lost",  lost_hit1,  1'b1);
        chk("s6.held",  map_out1,   128'd1 << 2);
        map_ready = 1'b1;
        tick(20);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
